rs232_bit_source: RTL
=====================

Name: rs232_bit_source

Overview:
- Upstream feeder for the BPSK transmitter's serial DATA input.
- Receives 8N1 bytes from the RS232 line and buffers them in a small FIFO.
- Serializes the buffered bytes LSB-first, one bit per request pulse from the modulator datapath (its data_rdy).
- Runs on the peripheral clock domain shared with the controller and sine datapath.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (9600 baud at ~1 MHz periph clock); must be >= 4.
- FIFO_DEPTH, 16, byte entries in the receive FIFO; power of 2.
- IDLE_BIT, 1'b0, value driven on data_bit when a request arrives with nothing buffered.

Ports:
- clk  in  1  peripheral clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous RS232 line (idle high); 2-flop synchronized internally.
- bit_req  in  1  single-cycle pulse: modulator wants the next bit.
- data_bit  out  1  current bit presented to the modulator; registered.
- bit_valid  out  1  1-cycle pulse, cycle after bit_req, when data_bit came from real data.
- underrun  out  1  1-cycle pulse, cycle after bit_req, when IDLE_BIT was substituted.
- frame_err  out  1  1-cycle pulse: stop bit sampled low; byte discarded.
- overrun  out  1  1-cycle pulse: byte completed while FIFO full; byte dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently in the FIFO.

Behaviour:
- Reset (synchronous, active-high):
  - data_bit=IDLE_BIT; all pulses 0; fifo_level=0.
  - RX FSM returns to IDLE; shift register emptied.
  - Synchronizer flops set to 1.
  - Reset mid-byte discards the partial byte; reset mid-stream discards the FIFO and the remaining bits.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge on synchronized rx -> START, baud counter cleared.
  - START: at CLKS_PER_BIT/2, rx high -> IDLE (glitch, no error); rx low -> DATA, counter cleared.
  - DATA: sample every CLKS_PER_BIT cycles; bits shifted in LSB first; after 8th sample -> STOP.
  - STOP: sample after CLKS_PER_BIT.
    - rx=1 -> push byte.
    - rx=0 -> frame_err pulse, no push.
    - Either case -> IDLE; a new start bit may be detected the next cycle.
  - Push when fifo_level==FIFO_DEPTH and no pop in the same cycle -> overrun pulse, byte dropped, FIFO unchanged.
  - Push and pop in the same cycle when full are both honoured; level unchanged.
- Serializer holds shreg[7:0] and idx[3:0]; idx==8 means empty.
  - bit_req, idx<8: data_bit<=shreg[idx], idx++, bit_valid pulse.
  - bit_req, idx==8, FIFO non-empty: pop; data_bit<=head[0]; shreg<=head; idx<=1; bit_valid pulse (FIFO is first-word-fall-through).
  - bit_req, idx==8, FIFO empty: data_bit<=IDLE_BIT, underrun pulse.
  - No bit_req: data_bit holds its value.
- Latency:
  - bit_req to data_bit and pulses: 1 cycle.
  - rx stop-bit sample to fifo_level increment: 1 cycle.
- bit_req asserted on consecutive cycles: each pulse is served independently.
- FIFO pointers wrap modulo FIFO_DEPTH; the level counter disambiguates full from empty.

Decomposition:
- Shared package (tx_pkg): BYTE_W=8; RX state enum (IDLE, START, DATA, STOP); default baud constant.
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH; ports push, pop, din, dout, level, full, empty).
- UART RX and serializer stay in the top module.

Test Plan:
- 0xA5 sent on rx, then 8 bit_req pulses spaced 50 cycles apart -> data_bit sequence 1,0,1,0,0,1,0,1, each with bit_valid; fifo_level goes 1 then 0 on the first request.
- No data, bit_req pulse -> data_bit=0, underrun=1 for 1 cycle, bit_valid=0.
- 17 bytes back-to-back, no requests (DEPTH 16) -> fifo_level=16 and one overrun pulse at byte 17; drain returns bytes 1..16 in order.
- Byte 0x3C with stop bit forced low -> frame_err pulse, fifo_level stays 0; next valid byte 0x81 received correctly.
- rx low pulse of CLKS_PER_BIT/4 cycles -> no push, no frame_err; FSM back in IDLE.
- rst asserted during DATA bit 4 of 0xFF with 2 bytes buffered -> next cycle fifo_level=0, data_bit=0; fresh byte 0x55 afterwards serializes as 1,0,1,0,1,0,1,0.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the BPSK transmitter front end.
// Byte width, RX state encoding and the default baud divider.
package tx_pkg;

    localparam int BYTE_W = 8;

    // 9600 baud at a ~1 MHz peripheral clock
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// The level counter tells full apart from empty; pointers wrap freely.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands if a pop frees a slot this cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and level bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rs232_bit_source.sv
// RS232 8N1 receiver feeding a byte FIFO, serialized LSB-first
// one bit per request from the BPSK modulator datapath.
module rs232_bit_source
    import tx_pkg::*;
#(
    parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int   FIFO_DEPTH   = 16,
    parameter logic IDLE_BIT     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          bit_req,
    output logic                          data_bit,
    output logic                          bit_valid,
    output logic                          underrun,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    logic              rx_s1;
    logic              rx_s2;
    logic              rx_d;

    rx_state_t         state;
    rx_state_t         state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_n;
    logic [BYTE_W-1:0] rx_byte;
    logic [BYTE_W-1:0] rx_byte_n;
    logic              push;
    logic              ferr_n;

    logic              pop;
    logic              full;
    logic              empty;
    logic [BYTE_W-1:0] head;

    logic [BYTE_W-1:0] ser_byte;
    logic [3:0]        idx;

    // Two-flop synchronizer plus one history flop for start-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // RX FSM state register, baud counter and receive shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            rx_byte <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            rx_byte <= rx_byte_n;
        end
    end

    // RX FSM next state: mid-bit sampling driven by the baud counter
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        rx_byte_n = rx_byte;
        push      = 1'b0;
        ferr_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_d && !rx_s2) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    rx_byte_n = {rx_s2, rx_byte[BYTE_W-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    push    = rx_s2;
                    ferr_n  = !rx_s2;
                end
            end
        endcase
    end

    // Error pulses are registered so they line up with the level update
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_n;
            overrun   <= push && full && !pop;
        end
    end

    assign pop = bit_req && idx[3] && !empty;

    sync_fifo_fwft #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    // Serializer: idx==8 means the current byte is used up
    always_ff @(posedge clk) begin
        if (rst) begin
            data_bit  <= IDLE_BIT;
            bit_valid <= 1'b0;
            underrun  <= 1'b0;
            ser_byte  <= '0;
            idx       <= 4'd8;
        end else begin
            bit_valid <= 1'b0;
            underrun  <= 1'b0;
            if (bit_req) begin
                if (!idx[3]) begin
                    data_bit  <= ser_byte[idx[2:0]];
                    idx       <= idx + 1'b1;
                    bit_valid <= 1'b1;
                end else if (!empty) begin
                    data_bit  <= head[0];
                    ser_byte  <= head;
                    idx       <= 4'd1;
                    bit_valid <= 1'b1;
                end else begin
                    data_bit  <= IDLE_BIT;
                    underrun  <= 1'b1;
                end
            end
        end
    end

endmodule
